// File: rtl/chunk_write_queue.sv
// rtl/chunk_write_queue.sv - coalescing chunk write queue between pixel stacker and DDR write port
module chunk_write_queue #(
    parameter  int HRES  = 1280,
    parameter  int VRES  = 720,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(HRES * VRES / 8),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [CW-1:0]         chunk_addr_in,
    input  logic [7:0][15:0]      chunk_data_in,
    input  logic [15:0]           chunk_strobe_in,
    input  logic                  chunk_valid_in,
    output logic                  chunk_ready_out,
    output logic [26:0]           mem_addr_out,
    output logic [7:0][15:0]      mem_data_out,
    output logic [15:0]           mem_mask_out,
    output logic                  mem_valid_out,
    input  logic                  mem_ready_in,
    output logic [PW:0]           count_out,
    output logic [15:0]           merge_count_out
);

    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] MERGE_MIN  = (PW + 1)'(2);
    localparam int          ADDR_PAD   = 27 - CW - 4;

    // Entry storage: one slot per queued chunk
    logic [CW-1:0] r_addr [DEPTH];
    logic [127:0]  r_data [DEPTH];
    logic [15:0]   r_strb [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [15:0]   r_merge_count;

    logic [PW-1:0] w_youngest;
    logic [127:0]  w_in_data;
    logic [127:0]  w_merged_data;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_merge;
    logic          w_alloc;

    assign w_in_data  = chunk_data_in;
    assign w_youngest = r_tail - 1'b1;

    // Ready depends only on registered occupancy so mem_ready_in never reaches it
    assign chunk_ready_out = (r_count != FULL_COUNT);
    assign mem_valid_out   = (r_count != '0);

    assign w_push = chunk_valid_in && chunk_ready_out;
    assign w_pop  = mem_valid_out && mem_ready_in;
    assign w_drop = w_push && (chunk_strobe_in == 16'h0000);

    // With two or more entries the youngest is never the head, so merging cannot disturb the presented command
    assign w_merge = w_push && !w_drop && (r_count >= MERGE_MIN) &&
                     (r_addr[w_youngest] == chunk_addr_in);
    assign w_alloc = w_push && !w_drop && !w_merge;

    // Byte-wise overlay of the incoming chunk onto the youngest entry
    always_comb begin
        w_merged_data = r_data[w_youngest];
        for (int j = 0; j < 16; j++) begin
            if (chunk_strobe_in[j]) begin
                w_merged_data[j*8 +: 8] = w_in_data[j*8 +: 8];
            end
        end
    end

    // Entry writes: allocate at tail, or merge into the youngest entry
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_strb[i] <= '0;
            end
        end else if (w_alloc) begin
            r_addr[r_tail] <= chunk_addr_in;
            r_data[r_tail] <= w_in_data;
            r_strb[r_tail] <= chunk_strobe_in;
        end else if (w_merge) begin
            r_data[w_youngest] <= w_merged_data;
            r_strb[w_youngest] <= r_strb[w_youngest] | chunk_strobe_in;
        end
    end

    // Pointer and occupancy bookkeeping; merges and drops never move the tail
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_alloc && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_alloc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Saturating count of coalesced writes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_merge_count <= '0;
        end else if (w_merge && (r_merge_count != 16'hFFFF)) begin
            r_merge_count <= r_merge_count + 16'd1;
        end
    end

    // Command fields decode straight from the head entry (first-word-fall-through)
    assign mem_addr_out    = {{ADDR_PAD{1'b0}}, r_addr[r_head], 4'b0000};
    assign mem_data_out    = r_data[r_head];
    assign mem_mask_out    = ~r_strb[r_head];
    assign count_out       = r_count;
    assign merge_count_out = r_merge_count;

endmodule

// File: tb/tb_chunk_write_queue.sv
// tb/tb_chunk_write_queue.sv - directed self-checking bench for chunk_write_queue
module tb_chunk_write_queue;

    logic             clk_in;
    logic             rst_in;
    logic [16:0]      chunk_addr_in;
    logic [7:0][15:0] chunk_data_in;
    logic [15:0]      chunk_strobe_in;
    logic             chunk_valid_in;
    logic             chunk_ready_out;
    logic [26:0]      mem_addr_out;
    logic [7:0][15:0] mem_data_out;
    logic [15:0]      mem_mask_out;
    logic             mem_valid_out;
    logic             mem_ready_in;
    logic [3:0]       count_out;
    logic [15:0]      merge_count_out;

    int n_tests = 0;
    int n_fail  = 0;

    chunk_write_queue dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .chunk_addr_in   (chunk_addr_in),
        .chunk_data_in   (chunk_data_in),
        .chunk_strobe_in (chunk_strobe_in),
        .chunk_valid_in  (chunk_valid_in),
        .chunk_ready_out (chunk_ready_out),
        .mem_addr_out    (mem_addr_out),
        .mem_data_out    (mem_data_out),
        .mem_mask_out    (mem_mask_out),
        .mem_valid_out   (mem_valid_out),
        .mem_ready_in    (mem_ready_in),
        .count_out       (count_out),
        .merge_count_out (merge_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0][15:0] lanes(input logic [15:0] base);
        logic [7:0][15:0] v;
        for (int i = 0; i < 8; i++) v[i] = base + 16'(i);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst_in          = 1'b1;
        chunk_valid_in  = 1'b0;
        chunk_addr_in   = '0;
        chunk_data_in   = '0;
        chunk_strobe_in = '0;
        mem_ready_in    = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic push(input logic [16:0] a, input logic [7:0][15:0] d, input logic [15:0] s);
        @(negedge clk_in);
        chunk_addr_in   = a;
        chunk_data_in   = d;
        chunk_strobe_in = s;
        chunk_valid_in  = 1'b1;
        @(posedge clk_in);
        #1 chunk_valid_in = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk_in);
        mem_ready_in = 1'b1;
        @(posedge clk_in);
        #1 mem_ready_in = 1'b0;
    endtask

    logic [7:0][15:0] exp_d;

    initial begin
        rst_in          = 1'b1;
        chunk_valid_in  = 1'b0;
        chunk_addr_in   = '0;
        chunk_data_in   = '0;
        chunk_strobe_in = '0;
        mem_ready_in    = 1'b0;

        // reset state
        #1;
        check("rst_valid", mem_valid_out, 0);
        check("rst_ready", chunk_ready_out, 1);
        check("rst_addr", mem_addr_out, 0);
        check("rst_data", mem_data_out, 0);
        check("rst_mask", mem_mask_out, 16'hFFFF);
        check("rst_count", count_out, 0);
        check("rst_merge", merge_count_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // single write
        @(negedge clk_in);
        mem_ready_in = 1'b1;
        push(17'h00005, lanes(16'h1000), 16'h0003);
        @(negedge clk_in);
        check("sw_valid", mem_valid_out, 1);
        check("sw_addr", mem_addr_out, 27'h50);
        check("sw_mask", mem_mask_out, 16'hFFFC);
        check("sw_data", mem_data_out, lanes(16'h1000));
        check("sw_count1", count_out, 1);
        @(negedge clk_in);
        check("sw_count0", count_out, 0);
        check("sw_valid0", mem_valid_out, 0);

        // merge into youngest
        do_reset();
        push(17'd1, lanes(16'h1100), 16'h000F);
        push(17'd2, lanes(16'h2000), 16'h0003);
        exp_d = lanes(16'hDEAD);
        exp_d[1] = 16'hBEEF;
        push(17'd2, exp_d, 16'h000C);
        @(negedge clk_in);
        check("mg_count", count_out, 2);
        check("mg_merges", merge_count_out, 1);
        check("mg_head_addr", mem_addr_out, 27'h10);
        check("mg_head_mask", mem_mask_out, 16'hFFF0);
        pop_one();
        @(negedge clk_in);
        exp_d = lanes(16'h2000);
        exp_d[1] = 16'hBEEF;
        check("mg_e2_count", count_out, 1);
        check("mg_e2_addr", mem_addr_out, 27'h20);
        check("mg_e2_mask", mem_mask_out, 16'hFFF0);
        check("mg_e2_data", mem_data_out, exp_d);
        pop_one();
        @(negedge clk_in);
        check("mg_empty", count_out, 0);

        // no merge into head; merge allowed once count reaches 2
        do_reset();
        push(17'd3, lanes(16'h3000), 16'hFFFF);
        push(17'd3, lanes(16'h4000), 16'hFFFF);
        @(negedge clk_in);
        check("nh_count", count_out, 2);
        check("nh_merges", merge_count_out, 0);
        check("nh_head", mem_data_out, lanes(16'h3000));
        push(17'd3, lanes(16'h5000), 16'h00FF);
        @(negedge clk_in);
        check("nh_count2", count_out, 2);
        check("nh_merges2", merge_count_out, 1);
        check("nh_head2", mem_data_out, lanes(16'h3000));
        pop_one();
        @(negedge clk_in);
        exp_d = lanes(16'h4000);
        for (int i = 0; i < 4; i++) exp_d[i] = 16'h5000 + 16'(i);
        check("nh_second", mem_data_out, exp_d);

        // full / backpressure with wrap
        do_reset();
        for (int i = 0; i < 8; i++) push(17'h10 + 17'(i), lanes(16'(i)), 16'hFFFF);
        @(negedge clk_in);
        check("fl_count", count_out, 8);
        check("fl_ready", chunk_ready_out, 0);
        check("fl_head", mem_addr_out, 27'h100);
        chunk_addr_in   = 17'h20;
        chunk_data_in   = lanes(16'h0900);
        chunk_strobe_in = 16'hFFFF;
        chunk_valid_in  = 1'b1;
        mem_ready_in    = 1'b1;
        #1 check("fl_ready_nocomb", chunk_ready_out, 0);
        @(negedge clk_in);
        check("fl_count7", count_out, 7);
        check("fl_ready1", chunk_ready_out, 1);
        check("fl_head2", mem_addr_out, 27'h110);
        mem_ready_in = 1'b0;
        @(posedge clk_in);
        #1 chunk_valid_in = 1'b0;
        @(negedge clk_in);
        check("fl_count8", count_out, 8);
        mem_ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("fl_order_v", mem_valid_out, 1);
            check("fl_order", mem_addr_out, (k < 7) ? (32'h11 + 32'(k)) * 16 : 32'h200);
            @(negedge clk_in);
        end
        mem_ready_in = 1'b0;
        check("fl_drained", count_out, 0);

        // drop
        do_reset();
        push(17'd7, lanes(16'h7000), 16'h000F);
        push(17'd7, lanes(16'h0000), 16'h0000);
        @(negedge clk_in);
        check("dr_count", count_out, 1);
        check("dr_merges", merge_count_out, 0);
        check("dr_data", mem_data_out, lanes(16'h7000));
        check("dr_mask", mem_mask_out, 16'hFFF0);

        // steady push + pop at count 3
        do_reset();
        for (int i = 0; i < 3; i++) push(17'h100 + 17'(i), lanes(16'(i)), 16'hFFFF);
        @(negedge clk_in);
        mem_ready_in    = 1'b1;
        chunk_valid_in  = 1'b1;
        chunk_strobe_in = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            chunk_addr_in = 17'h103 + 17'(k);
            chunk_data_in = lanes(16'(k));
            #1;
            check("ss_count", count_out, 3);
            check("ss_addr", mem_addr_out, (32'h100 + 32'(k)) * 16);
            @(negedge clk_in);
        end
        chunk_valid_in = 1'b0;
        mem_ready_in   = 1'b0;
        check("ss_end", count_out, 3);

        // asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 5; i++) push(17'h200 + 17'(i), lanes(16'(i)), 16'hFFFF);
        @(negedge clk_in);
        check("ar_count5", count_out, 5);
        #2 rst_in = 1'b1;
        #1;
        check("ar_valid", mem_valid_out, 0);
        check("ar_count", count_out, 0);
        check("ar_ready", chunk_ready_out, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("ar_post_count", count_out, 0);
        check("ar_post_valid", mem_valid_out, 0);
        check("ar_post_mask", mem_mask_out, 16'hFFFF);
        check("ar_post_addr", mem_addr_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
